// File: rtl/string_conv_pkg.sv
// Shared types and ASCII constants for the streaming string-to-integer parser.
package string_conv_pkg;

  typedef enum logic [1:0] {
    RADIX_DEC = 2'd0,
    RADIX_HEX = 2'd1,
    RADIX_OCT = 2'd2,
    RADIX_BIN = 2'd3
  } radix_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SKIP  = 2'd2,
    ST_DONE  = 2'd3
  } parser_state_e;

  localparam logic [7:0] CH_MINUS      = 8'h2D;
  localparam logic [7:0] CH_UNDERSCORE = 8'h5F;
  localparam logic [7:0] CH_NUL        = 8'h00;

  // Per-character classification produced by the digit decoder.
  typedef struct packed {
    logic       is_digit;
    logic       is_underscore;
    logic [3:0] digit;
  } digit_info_t;

endpackage

// File: rtl/char_digit_decode.sv
// Classifies one ASCII character against the digit set of the selected radix.
module char_digit_decode
  import string_conv_pkg::*;
(
  input  logic [7:0]  in_char,
  input  radix_e      radix,
  output digit_info_t info_c
);

  logic [3:0] num_val;
  logic [3:0] alpha_lo_val;
  logic [3:0] alpha_hi_val;

  assign num_val      = 4'(in_char - 8'h30);
  assign alpha_lo_val = 4'(in_char - 8'h57);
  assign alpha_hi_val = 4'(in_char - 8'h37);

  always_comb begin
    info_c               = '0;
    info_c.is_underscore = (in_char == CH_UNDERSCORE);
    if (in_char >= 8'h30 && in_char <= 8'h39) begin
      info_c.digit = num_val;
      unique case (radix)
        RADIX_DEC, RADIX_HEX: info_c.is_digit = 1'b1;
        RADIX_OCT:            info_c.is_digit = (num_val < 4'd8);
        RADIX_BIN:            info_c.is_digit = (num_val < 4'd2);
        default:              info_c.is_digit = 1'b0;
      endcase
    end else if (in_char >= 8'h61 && in_char <= 8'h66) begin
      info_c.digit    = alpha_lo_val;
      info_c.is_digit = (radix == RADIX_HEX);
    end else if (in_char >= 8'h41 && in_char <= 8'h46) begin
      info_c.digit    = alpha_hi_val;
      info_c.is_digit = (radix == RADIX_HEX);
    end
  end

endmodule

// File: rtl/string_radix_parser.sv
// Streaming ASCII-to-integer converter: one character per beat, runtime radix,
// W-bit two's-complement result with overflow, sign and digit-count status.
module string_radix_parser
  import string_conv_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_value,
  output logic             out_overflow,
  output logic             out_neg,
  output logic [CNT_W-1:0] out_digits
);

  localparam int unsigned AW = W + 4;

  parser_state_e    state_q, state_d;
  radix_e           mode_q, mode_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             beat;
  logic             take;
  logic             load_out;
  radix_e           radix_c;
  digit_info_t      info_c;
  logic [AW-1:0]    acc_ext;
  logic [AW-1:0]    step_c;
  logic             step_ovf;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = (state_q != ST_DONE);
  assign beat     = in_valid && in_ready;
  assign take     = out_valid && out_ready;

  // Mode is taken live on the first beat and from the latch afterwards.
  assign radix_c = (state_q == ST_IDLE) ? radix_e'(in_mode) : mode_q;

  char_digit_decode u_decode (
    .in_char (in_char),
    .radix   (radix_c),
    .info_c  (info_c)
  );

  // One accumulation step in W+4 bits so the lost high bits are visible.
  always_comb begin
    acc_ext = AW'(acc_q);
    unique case (radix_c)
      RADIX_DEC: step_c = (acc_ext << 3) + (acc_ext << 1) + AW'(info_c.digit);
      RADIX_HEX: step_c = (acc_ext << 4) | AW'(info_c.digit);
      RADIX_OCT: step_c = (acc_ext << 3) | AW'(info_c.digit);
      RADIX_BIN: step_c = (acc_ext << 1) | AW'(info_c.digit);
      default:   step_c = '0;
    endcase
  end

  assign step_ovf = |step_c[AW-1:W];
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= RADIX_DEC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat) begin
          state_d = ST_ACCUM;
          if (state_q == ST_IDLE) begin
            mode_d = radix_c;
          end
          if (state_q == ST_IDLE && in_char == CH_MINUS && radix_c == RADIX_DEC) begin
            neg_d = 1'b1;
          end else if (info_c.is_digit) begin
            acc_d = step_c[W-1:0];
            ovf_d = ovf_q | step_ovf;
            cnt_d = cnt_inc;
          end else if (!info_c.is_underscore) begin
            state_d = ST_SKIP;
          end
          if (in_last) begin
            state_d  = ST_DONE;
            load_out = 1'b1;
          end
        end
      end
      ST_SKIP: begin
        if (beat && in_last) begin
          state_d  = ST_DONE;
          load_out = 1'b1;
        end
      end
      ST_DONE: begin
        if (take) begin
          state_d = ST_IDLE;
          mode_d  = RADIX_DEC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          neg_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result registers: loaded with the final beat folded in, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_overflow <= 1'b0;
      out_neg      <= 1'b0;
      out_digits   <= '0;
    end else if (load_out) begin
      out_valid    <= 1'b1;
      out_value    <= neg_d ? W'(-acc_d) : acc_d;
      out_overflow <= ovf_d;
      out_neg      <= neg_d;
      out_digits   <= cnt_d;
    end else if (take) begin
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_overflow <= 1'b0;
      out_neg      <= 1'b0;
      out_digits   <= '0;
    end
  end

endmodule
